// File: rtl/prim_pkg.sv
//------------------------------------------------------------------------------
// Module   : prim_pkg
// Purpose  : Shared types and helpers for the prim stream primitives.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package prim_pkg;

    localparam int PRIM_MAX_W    = 1024;
    localparam int PRIM_MAX_BEAT = 256;

    typedef enum logic [0:0] {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } prim_ser_state_e;

    // Beat idx of a word made of ratio slices of width bits; the caller truncates to its width.
    function automatic logic [PRIM_MAX_BEAT-1:0] prim_beat_sel(
        input logic [PRIM_MAX_W-1:0] word,
        input int                    idx,
        input int                    width,
        input int                    ratio,
        input logic                  lsb_first
    );
        int slot;
        slot = lsb_first ? idx : (ratio - 1 - idx);
        return PRIM_MAX_BEAT'(word >> (slot * width));
    endfunction

endpackage

`default_nettype wire

// File: rtl/prim_stream_ser.sv
//------------------------------------------------------------------------------
// Module   : prim_stream_ser
// Purpose  : Width-down stream serializer, one wide word out as RATIO beats.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module prim_stream_ser
    import prim_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int RATIO     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   urdy_o,
    input  logic                   uvld_i,
    input  logic [WIDTH*RATIO-1:0] udat_i,
    input  logic                   dstall_i,
    input  logic                   drdy_i,
    output logic                   dvld_o,
    output logic [WIDTH-1:0]       ddat_o,
    output logic                   dlast_o
);

    localparam int             CW       = $clog2(RATIO);
    localparam logic [CW-1:0]  CNT_LAST = CW'(RATIO - 1);
    localparam logic [0:0]     S_IDLE   = SER_IDLE;
    localparam logic [0:0]     S_SEND   = SER_SEND;

    logic [WIDTH*RATIO-1:0] hold_q;
    logic [CW-1:0]          cnt_q;
    logic [0:0]             busy_q;

    logic                   active;
    logic                   last;
    logic                   dbeat;
    logic                   ubeat;
    logic [WIDTH-1:0]       beat;

    // Outputs are gated by reset so they read idle even before the state clears.
    assign active  = (busy_q == S_SEND) && reset;
    assign last    = active && (cnt_q == CNT_LAST);
    assign dvld_o  = active && !dstall_i;
    assign dbeat   = dvld_o && drdy_i;
    assign urdy_o  = reset && ((busy_q == S_IDLE) || (last && dbeat));
    assign ubeat   = urdy_o && uvld_i;
    assign dlast_o = last;

    assign beat   = WIDTH'(prim_beat_sel(PRIM_MAX_W'(hold_q), 32'(cnt_q), WIDTH, RATIO,
                                         LSB_FIRST != 0));
    assign ddat_o = reset ? beat : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q <= S_IDLE;
            cnt_q  <= '0;
            hold_q <= '0;
        end else if (ubeat) begin
            hold_q <= udat_i;
            cnt_q  <= '0;
            busy_q <= S_SEND;
        end else if (dbeat) begin
            if (last) begin
                busy_q <= S_IDLE;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    generate
        if (RATIO != (1 << CW)) begin : g_cnt_chk
            always_ff @(posedge clk) begin
                if (reset) begin
                    assert (cnt_q <= CNT_LAST);
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire
